// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Write-port arbiter and RAW scoreboard for the register file.
//                Shares the single register-file write port among NREQ
//                write-back producers using a valid/ready handshake. Writes
//                reach the register file one cycle after the handshake.
//                A scoreboard tracks destination registers with outstanding
//                writes, so the issue stage can stall on RAW hazards.
//  Options     : RFWB_FIXED_PRIO_EN - when defined, the arbiter uses fixed
//                priority (lowest index wins) and has no round-robin pointer.
//                When undefined (default), the arbiter uses round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_rd,
    output logic [DW-1:0]        rf_wdata,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_set_rd,
    input  logic [AW-1:0]        chk_rs,
    input  logic [AW-1:0]        chk_rt,
    output logic                 hazard,
    output logic [(1<<AW)-1:0]   sb_pending
);

    localparam int NREG = 1 << AW;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Grant candidates: the set of valid requesters, in priority order so
    // that the lowest set bit is the winner.
    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_grant;
    logic            w_xfer;
    logic [AW-1:0]   w_sel_rd;
    logic [DW-1:0]   w_sel_data;

`ifdef RFWB_FIXED_PRIO_EN
    assign w_cand = req_valid;
`else
    localparam logic [PW-1:0] c_LAST = PW'(NREQ - 1);

    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   w_gidx;
    logic [NREQ-1:0] w_upper;
    logic [NREQ-1:0] w_hi;

    // w_upper marks requesters at or above the round-robin pointer.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_upper
        localparam logic [PW-1:0] c_IDX = PW'(gi);
        assign w_upper[gi] = (c_IDX >= r_rr_ptr);
    end

    // Search from the pointer upward first, then wrap to the lowest index.
    assign w_hi   = req_valid & w_upper;
    assign w_cand = (|w_hi) ? w_hi : req_valid;

    // Encode the winning requester index for the pointer update.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = PW'(i);
            end
        end
    end

    // After a transfer, the requester following the winner gets first claim.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_gidx == c_LAST) ? '0 : w_gidx + PW'(1);
        end
    end
`endif

    // Isolate the lowest set candidate bit; no grant at all during reset.
    assign w_grant   = rst ? '0 : (w_cand & (~w_cand + NREQ'(1)));
    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;

    // Select the destination and data of the granted requester (one-hot).
    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = req_rd[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    logic            r_we;
    logic [AW-1:0]   r_rd;
    logic [DW-1:0]   r_wdata;

    // Output stage: present an accepted transfer to the register file one
    // cycle later. A write to register 0 is accepted but suppressed. Address
    // and data hold between transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_xfer && (w_sel_rd != '0);
            if (w_xfer) begin
                r_rd    <= w_sel_rd;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign rf_we    = r_we;
    assign rf_rd    = r_rd;
    assign rf_wdata = r_wdata;

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_nxt;

    // Next scoreboard state: a write leaving the output stage clears its
    // bit. A new issue to the same register overrides the clear because it
    // belongs to a younger producer. Register 0 never has a pending write.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_we) begin
            w_pend_nxt[r_rd] = 1'b0;
        end
        if (sb_set && (sb_set_rd != '0)) begin
            w_pend_nxt[sb_set_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign sb_pending = r_pend;
    assign hazard     = r_pend[chk_rs] | r_pend[chk_rt];

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Self-checking bench for rf_wb_arbiter: directed steps
//                followed by random traffic, compared with a behavioural
//                model of the arbitration, output stage and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_rd;
    logic [NREQ*DW-1:0]  req_data;
    logic                rf_we;
    logic [AW-1:0]       rf_rd;
    logic [DW-1:0]       rf_wdata;
    logic                sb_set;
    logic [AW-1:0]       sb_set_rd;
    logic [AW-1:0]       chk_rs;
    logic [AW-1:0]       chk_rt;
    logic                hazard;
    logic [NREG-1:0]     sb_pending;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    int              m_rr;
    bit              m_we;
    logic [AW-1:0]   m_rd;
    logic [DW-1:0]   m_data;
    logic [NREG-1:0] m_pend;
    logic [NREQ-1:0] last_g;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .sb_set     (sb_set),
        .sb_set_rd  (sb_set_rd),
        .chk_rs     (chk_rs),
        .chk_rt     (chk_rt),
        .hazard     (hazard),
        .sb_pending (sb_pending)
    );

    // Expected grant: first valid requester in search order.
    function automatic logic [NREQ-1:0] model_grant();
        int i;
        if (rst) return '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef RFWB_FIXED_PRIO_EN
            i = k;
`else
            i = (m_rr + k) % NREQ;
`endif
            if (req_valid[i]) return NREQ'(1) << i;
        end
        return '0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already applied just after a negedge.
    task automatic tick(input string tag);
        logic [NREQ-1:0] g;
        logic [NREG-1:0] np;
        #1;
        g = model_grant();
        check({tag, ".ready"},  64'(req_ready), 64'(g));
        check({tag, ".hazard"}, 64'(hazard),    64'(m_pend[chk_rs] | m_pend[chk_rt]));
        if (rst) begin
            m_we = 0; m_rd = '0; m_data = '0; m_pend = '0; m_rr = 0;
        end else begin
            np = m_pend;
            if (m_we) np[m_rd] = 1'b0;
            if (sb_set && sb_set_rd != '0) np[sb_set_rd] = 1'b1;
            m_pend = np;
            m_we = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    m_rd   = req_rd[i*AW +: AW];
                    m_data = req_data[i*DW +: DW];
                    m_we   = (m_rd != '0);
                    m_rr   = (i + 1) % NREQ;
                end
            end
        end
        last_g = g;
        @(negedge clk);
        check({tag, ".rf_we"},    64'(rf_we),      64'(m_we));
        check({tag, ".rf_rd"},    64'(rf_rd),      64'(m_rd));
        check({tag, ".rf_wdata"}, 64'(rf_wdata),   64'(m_data));
        check({tag, ".pending"},  64'(sb_pending), 64'(m_pend));
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_rd[i*AW +: AW]     = rd;
        req_data[i*DW +: DW]   = d;
    endtask

    initial begin
        m_rr = 0; m_we = 0; m_rd = '0; m_data = '0; m_pend = '0; last_g = '0;
        @(negedge clk);

        // Reset with every input active.
        rst = 1'b1;
        set_req(0, 1'b1, 5'd5, 32'h1111_1111);
        set_req(1, 1'b1, 5'd6, 32'h2222_2222);
        sb_set = 1'b1; sb_set_rd = 5'd7; chk_rs = 5'd7; chk_rt = 5'd7;
        tick("rst1");
        tick("rst2");
        check("rst.pending_zero", 64'(sb_pending), 64'd0);
        rst = 1'b0;
        req_valid = '0; sb_set = 1'b0; chk_rs = '0; chk_rt = '0;

        // Single transfer, latency one.
        set_req(0, 1'b1, 5'd4, 32'd32);
        tick("single");
        check("single.we", 64'(rf_we), 64'd1);
        check("single.rd", 64'(rf_rd), 64'd4);
        req_valid = '0;
        tick("single_idle");

        // Two requesters contending for four cycles from a fresh pointer.
        rst = 1'b1;
        tick("rst3");
        rst = 1'b0;
        set_req(0, 1'b1, 5'd5, 32'hA5A5_0005);
        set_req(1, 1'b1, 5'd6, 32'h5A5A_0006);
        for (int c = 0; c < 4; c++) tick("contend");
        req_valid = '0;

        // Register 0 write: handshaken, no register-file write.
        set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick("r0");
        check("r0.we", 64'(rf_we), 64'd0);
        req_valid = '0;

        // Scoreboard set, hazard, clear, and set-wins collision.
        sb_set = 1'b1; sb_set_rd = 5'd7; chk_rs = 5'd7; chk_rt = 5'd0;
        tick("sb_set");
        sb_set = 1'b0;
        tick("sb_haz");
        set_req(0, 1'b1, 5'd7, 32'hCAFE_0007);
        tick("sb_xfer");
        req_valid = '0;
        tick("sb_we");
        tick("sb_clr");
        sb_set = 1'b1; sb_set_rd = 5'd7;
        tick("sb_set2");
        sb_set = 1'b0;
        set_req(0, 1'b1, 5'd7, 32'hBEEF_0007);
        tick("sb_xfer2");
        req_valid = '0;
        sb_set = 1'b1; sb_set_rd = 5'd7;
        tick("sb_collide");
        sb_set = 1'b0;
        tick("sb_after");
        check("sb_collide.bit7", 64'(sb_pending[7]), 64'd1);

        // Reset right after an accepted transfer drops it.
        sb_set = 1'b1; sb_set_rd = 5'd9;
        tick("drop_set");
        sb_set = 1'b0;
        set_req(0, 1'b1, 5'd3, 32'h0000_0333);
        tick("drop_xfer");
        req_valid = '0;
        rst = 1'b1;
        tick("drop_rst");
        check("drop.we", 64'(rf_we), 64'd0);
        rst = 1'b0;
        tick("drop_idle");

        // Random traffic with requesters holding stable while stalled.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !last_g[i] && $urandom_range(0, 3) != 0)) begin
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
                end
            end
            sb_set    = 1'($urandom_range(0, 1));
            sb_set_rd = AW'($urandom_range(0, 7));
            chk_rs    = AW'($urandom_range(0, 7));
            chk_rt    = AW'($urandom_range(0, 31));
            rst       = ($urandom_range(0, 49) == 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
